// File: rtl/pulse_spacer_pkg.sv
// rtl/pulse_spacer_pkg.sv - shared FSM encodings and default sizing for the pulse spacer
package pulse_spacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_GAP  = 2'd2
  } spacer_state_e;

  // Defaults suit a 3:1 fast:slow ratio feeding a 2-flop capture stage.
  localparam int DEF_GAP   = 6;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/pulse_spacer_if.sv
// rtl/pulse_spacer_if.sv - event request in, spaced pulse and status out
interface pulse_spacer_if #(
  parameter int CNT_W = 4
) ();
  logic             event_in;
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  modport master (output event_in, input pulse_out, pending, busy, overflow);
  modport slave  (input event_in, output pulse_out, pending, busy, overflow);
endinterface

// File: rtl/pulse_spacer_edge_detect_rise.sv
// rtl/pulse_spacer_edge_detect_rise.sv - one-flop rising-edge detector on clk_fast
module edge_detect_rise (
  input  logic clk_fast,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;

  // Resetting to 0 makes a level already high at reset release count once.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/pulse_spacer.sv
// rtl/pulse_spacer.sv - counts bursty events and re-emits them as pulses spaced GAP+1 cycles apart
// Option: PULSE_SPACER_EDGE_DET_EN counts only 0->1 transitions of event_in.
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int GAP   = DEF_GAP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic         clk_fast,
  input  logic         rst_n,
  pulse_spacer_if.slave bus
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] FULL = {CNT_W{1'b1}};

  spacer_state_e    state_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             pulse_q;
  logic             evt, enter_fire, full, inc;

`ifdef PULSE_SPACER_EDGE_DET_EN
  edge_detect_rise u_edge (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .d_i      (bus.event_in),
    .rise_o   (evt)
  );
`else
  assign evt = bus.event_in;
`endif

  assign enter_fire = (pending_q != '0) &&
                      ((state_q == ST_IDLE) || (state_q == ST_GAP && gap_cnt_q == '0));
  assign full = (pending_q == FULL);
  // A simultaneous drain frees a slot, so an event at full is still accepted then.
  assign inc  = evt && (!full || enter_fire);

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (inc && !enter_fire)      pending_d = pending_q + CNT_W'(1);
    else if (!inc && enter_fire) pending_d = pending_q - CNT_W'(1);
    if (evt && !inc)             overflow_d = 1'b1;
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pulse_q    <= enter_fire;
      case (state_q)
        ST_IDLE: if (enter_fire) state_q <= ST_FIRE;
        ST_FIRE: begin
          state_q   <= ST_GAP;
          gap_cnt_q <= GW'(GAP - 1);
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) state_q <= enter_fire ? ST_FIRE : ST_IDLE;
          else                 gap_cnt_q <= gap_cnt_q - GW'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (pending_q != '0) || (state_q != ST_IDLE);
endmodule
